// File: rtl/io_bridge_pkg.sv
// Shared constants for the io_bridge memory-mapped I/O stage: register offsets,
// the default I/O window tag and STATUS bit positions.
package io_bridge_pkg;

  localparam logic [1:0] IO_TOP_DEF = 2'b11;

  localparam logic [3:0] IO_LED    = 4'h0;
  localparam logic [3:0] IO_SW     = 4'h1;
  localparam logic [3:0] IO_BTN    = 4'h2;
  localparam logic [3:0] IO_TCOUNT = 4'h3;
  localparam logic [3:0] IO_TCMP   = 4'h4;
  localparam logic [3:0] IO_STATUS = 4'h5;

  localparam int ST_MATCH = 0;
  localparam int ST_BTN   = 1;

endpackage

// File: rtl/io_bridge_sync_edge.sv
// io_sync_edge: W-bit two-flop synchronizer with a third flop for rising-edge pulses.
module io_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1, s2, s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~s3;

endmodule

// File: rtl/io_bridge.sv
// io_bridge: I/O window decode, LED/SW/BTN/timer registers and read-data merge.
// Timer, TCMP, STATUS match bit and timer_irq exist only with IO_BRIDGE_TIMER_EN defined.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int         SW_W     = 16,
  parameter int         BTN_W    = 4,
  parameter int         PRESCALE = 16,
  parameter logic [1:0] IO_TOP   = IO_TOP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      adr,
  input  logic [15:0]      writedata,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [15:0]      mem_rdata,
  input  logic [SW_W-1:0]  sw,
  input  logic [BTN_W-1:0] btn,
  output logic             mem_en,
  output logic [15:0]      memdata,
  output logic [15:0]      led,
  output logic             timer_irq
);

  logic             io_sel, wr, rd;
  logic [3:0]       off;
  logic [SW_W-1:0]  sw_s, sw_rise_unused;
  logic [BTN_W-1:0] btn_rise, btn_sync_unused, btn_cap;
  logic [15:0]      io_rdata_d, io_rdata_q, status;
  logic             rd_io_q, match_q;
  logic [9:0]       adr_unused;

  assign io_sel     = (adr[15:14] == IO_TOP);
  assign mem_en     = ~io_sel;
  assign off        = adr[3:0];
  assign adr_unused = adr[13:4];
  assign wr         = memwrite & io_sel;
  assign rd         = memread & io_sel & ~memwrite;

  io_sync_edge #(.W(SW_W)) u_sw_sync (
    .clk(clk), .rst(rst), .d(sw), .sync(sw_s), .rise(sw_rise_unused)
  );

  io_sync_edge #(.W(BTN_W)) u_btn_sync (
    .clk(clk), .rst(rst), .d(btn), .sync(btn_sync_unused), .rise(btn_rise)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led     <= '0;
      btn_cap <= '0;
    end else begin
      if (wr && off == IO_LED) led <= writedata;
      // a fresh edge overrides a same-cycle W1C
      if (wr && off == IO_BTN) btn_cap <= (btn_cap & ~writedata[BTN_W-1:0]) | btn_rise;
      else                     btn_cap <= btn_cap | btn_rise;
    end
  end

`ifdef IO_BRIDGE_TIMER_EN
  localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PSC_W-1:0] psc;
  logic [15:0]      tcount, tcmp;
  logic             tick;

  assign tick = (psc == PSC_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc     <= '0;
      tcount  <= '0;
      tcmp    <= 16'hFFFF;
      match_q <= 1'b0;
    end else begin
      psc <= tick ? '0 : psc + PSC_W'(1);
      if (tick) tcount <= tcount + 16'd1;
      if (wr && off == IO_TCMP) tcmp <= writedata;
      if (tick && (tcount + 16'd1 == tcmp))
        match_q <= 1'b1;
      else if (wr && off == IO_STATUS && writedata[ST_MATCH])
        match_q <= 1'b0;
    end
  end
`else
  localparam int PRESCALE_UNUSED = PRESCALE;
  assign match_q = 1'b0;
`endif

  assign timer_irq = match_q;

  always_comb begin
    status           = '0;
    status[ST_MATCH] = match_q;
    status[ST_BTN]   = |btn_cap;
  end

  always_comb begin
    io_rdata_d = '0;
    case (off)
      IO_LED:    io_rdata_d = led;
      IO_SW:     io_rdata_d = 16'(sw_s);
      IO_BTN:    io_rdata_d = 16'(btn_cap);
`ifdef IO_BRIDGE_TIMER_EN
      IO_TCOUNT: io_rdata_d = tcount;
      IO_TCMP:   io_rdata_d = tcmp;
`endif
      IO_STATUS: io_rdata_d = status;
      default:   io_rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io_rdata_q <= '0;
      rd_io_q    <= 1'b0;
    end else begin
      rd_io_q <= rd;
      if (rd) io_rdata_q <= io_rdata_d;
    end
  end

  assign memdata = rd_io_q ? io_rdata_q : mem_rdata;

endmodule

// File: doc/io_bridge.md
Name: io_bridge

Overview:
- Memory-mapped I/O stage on the processor data bus, directly downstream of the datapath address/write-data outputs and alongside exmem.
- Decodes the I/O window (adr[15:14] == 2'b11) and generates the exmem enable.
- Holds LED, switch, button-capture and timer registers.
- Returns a merged read-data word (I/O or memory) to the datapath memdata input.

Parameters:
- SW_W, 16: switch input width (≤16).
- BTN_W, 4: button input width (≤16).
- PRESCALE, 16: clk cycles per timer tick (≥1).
- IO_TOP, 2'b11: value of adr[15:14] that selects I/O space.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- adr  in  16  bus address from datapath.
- writedata  in  16  store data from datapath.
- memread  in  1  load strobe.
- memwrite  in  1  store strobe.
- mem_rdata  in  16  read data from exmem.
- sw  in  SW_W  raw asynchronous switch inputs.
- btn  in  BTN_W  raw asynchronous button inputs, active-high.
- mem_en  out  1  exmem enable; low while adr is in I/O space.
- memdata  out  16  merged read data to datapath.
- led  out  16  LED output register.
- timer_irq  out  1  copy of the timer match flag.

Behaviour:
- Decode (combinational):
  - io_sel = (adr[15:14] == IO_TOP).
  - mem_en = ~io_sel.
  - Register offset is adr[3:0]. adr[13:4] is ignored, so registers alias across the window.
- Register map:
  - 0x0 LED: RW.
  - 0x1 SW: RO, synchronized value.
  - 0x2 BTN_CAP: bit i set on a rising edge of synced btn[i]; write-1-to-clear.
  - 0x3 TCOUNT: RO.
  - 0x4 TCMP: RW.
  - 0x5 STATUS: bit0 = match flag (W1C); bit1 = |BTN_CAP (RO).
  - 0x6–0xF: read 0, writes ignored.
  - Unused upper bits of SW/BTN_CAP read 0.
- Writes: take effect on the rising clk edge where memwrite & io_sel.
- Reads:
  - On the rising edge where memread & io_sel & ~memwrite, io_rdata_q captures the selected register and rd_io_q is set to 1. Any other cycle clears rd_io_q to 0.
  - memdata = rd_io_q ? io_rdata_q : mem_rdata. I/O read latency is 1 cycle, matching the exmem registered read.
  - memread & memwrite together to I/O: the write is performed, no read is captured, and rd_io_q = 0.
- Input synchronizers: 2-flop synchronizer on sw and btn. Edge detect compares sync stage 2 with a third flop.
- Button capture, same cycle set and clear: a new edge sets the bit even if W1C clears it that cycle (set wins).
- Timer:
  - Prescaler counts 0..PRESCALE-1. On wrap it issues a tick, and TCOUNT increments, wrapping 0xFFFF → 0x0000.
  - Match flag sets on the tick that makes TCOUNT == TCMP.
  - Same-cycle set and W1C clear: set wins.
  - Writing TCMP does not reset TCOUNT.
- Reset (rst low, asynchronous, any time including mid-access):
  - Cleared to 0: led, BTN_CAP, TCOUNT, prescaler, match flag, io_rdata_q, rd_io_q, all synchronizer flops.
  - TCMP resets to 0xFFFF.
  - memdata follows mem_rdata.
  - The first edge after rst rises behaves as cycle 0.
- timer_irq = match flag (registered, no extra latency).

Optional Feature:
- Macro: IO_BRIDGE_TIMER_EN.
- Defined: timer, TCMP, STATUS bit0 and timer_irq behave as above.
- Undefined:
  - Timer logic is removed.
  - Offsets 0x3/0x4 read 0 and ignore writes.
  - STATUS bit0 reads 0.
  - timer_irq is tied to 0.
  - Port list is unchanged.

Decomposition:
- Shared package:
  - Offset constants IO_LED, IO_SW, IO_BTN, IO_TCOUNT, IO_TCMP, IO_STATUS.
  - IO_TOP default.
  - STATUS bit indices.
- One natural sub-module: io_sync_edge, a parameterized-width 2-flop synchronizer with rising-edge pulse output. It is instantiated for btn; sw uses only its sync output.

Test Plan:
- Reset then store 0xA5A5 to adr 0xC000 → led = 0xA5A5 next edge, mem_en = 0 during the store; load 0xC000 → memdata = 0xA5A5 one cycle later.
- Load adr 0x1234 with mem_rdata = 0xBEEF → mem_en = 1, memdata = 0xBEEF, rd_io_q stays 0.
- sw = 0x00F0 held 3 cycles, load 0xC001 → memdata = 0x00F0; sw changes 1 cycle before load → old value returned.
- Pulse btn[2] for 4 cycles → BTN_CAP = 0x0004, STATUS = 0x0002; store 0x0004 to 0xC002 in the same cycle as a new btn[2] edge → bit stays set.
- IO_BRIDGE_TIMER_EN, PRESCALE = 4, TCMP = 3 → timer_irq rises after 12 clks; W1C 0x0001 to 0xC005 clears it; TCOUNT wraps 0xFFFF → 0 without a spurious flag unless TCMP = 0.
- Assert rst mid-load of 0xC000 → memdata immediately follows mem_rdata, led = 0, TCMP reads 0xFFFF after release.
